polyvec_reader: RTL and testbench

POLYVEC_READER -- requirements
Module: polyvec_reader

---
 rtl/polyvec_reader_pkg.sv | 29 ++
 rtl/polyvec_reader_fifo.sv | 57 +++++
 rtl/polyvec_reader.sv | 183 ++++++++++++++++++
 tb/tb_polyvec_reader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polyvec_reader_pkg.sv
// Shared definitions for the polyvec reader: FSM encoding, BRAM latency
// default and the skid-FIFO sizing rule.
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

package polyvec_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BRAM_DELAY = `COMMON_BRAM_DELAY;

    // Room for every read that can be in flight plus one registered beat and
    // one beat of slack so issuing never has to look at the current pop.
    localparam int FIFO_SLACK = 2;

    function automatic int fifo_depth(input int delay);
        return delay + FIFO_SLACK;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/polyvec_reader_fifo.sv
// rd_skid_fifo: small synchronous FIFO catching BRAM returns so that
// downstream back-pressure never loses data already requested.
module rd_skid_fifo
    import polyvec_reader_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/polyvec_reader.sv
// polyvec_reader: walks every row of every polynomial in a banked BRAM,
// issuing one row read per cycle under credit control and streaming the
// returned rows out as valid/ready beats.
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

module polyvec_reader
    import polyvec_reader_pkg::*;
#(
    parameter  int COE_WIDTH         = 39,
    parameter  int ADDR_WIDTH        = 9,
    parameter  int NUM_POLY          = 8,
    parameter  int NUM_BASE_BANK     = 8,
    parameter  int COMMON_BRAM_DELAY = `COMMON_BRAM_DELAY,
    localparam int PIDX_W            = idx_width(NUM_POLY)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [ADDR_WIDTH:0]                           len,
    output logic [ADDR_WIDTH*NUM_BASE_BANK*NUM_POLY-1:0]  addrb,
    input  logic [COE_WIDTH*NUM_BASE_BANK*NUM_POLY-1:0]   doutb,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [COE_WIDTH*NUM_BASE_BANK-1:0]            m_data,
    output logic [PIDX_W-1:0]                             m_poly,
    output logic                                          m_last,
    output logic                                          busy,
    output logic                                          done
);

    localparam int D       = COMMON_BRAM_DELAY;
    localparam int DEPTH   = fifo_depth(D);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ROW_W   = ADDR_WIDTH + 1;
    localparam int BEAT_W  = COE_WIDTH * NUM_BASE_BANK;
    localparam int ENTRY_W = 1 + PIDX_W + BEAT_W;
    localparam logic [ROW_W-1:0] MAX_LEN = ROW_W'(1 << ADDR_WIDTH);

    state_t             state;
    state_t             state_next;
    logic [ROW_W-1:0]   len_reg;
    logic [ROW_W-1:0]   len_clamped;
    logic [ROW_W-1:0]   cur_len;
    logic [ROW_W-1:0]   row_cnt;
    logic [PIDX_W-1:0]  poly_cnt;
    logic               accept;
    logic               room;
    logic               issue;
    logic               row_end;
    logic               issue_last;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   in_flight;
    logic [D-1:0]       dl_vld;
    logic [D-1:0]       dl_last;
    logic [PIDX_W-1:0]  dl_poly [D];
    logic [PIDX_W-1:0]  ret_poly;
    logic [BEAT_W-1:0]  ret_data;
    logic [ENTRY_W-1:0] head;
    logic               fifo_empty;
    logic               head_last;
    logic               xfer;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    assign accept      = (state == ST_IDLE) && start;
    // The first read goes out in the accepting cycle, before len is registered.
    assign cur_len     = (state == ST_IDLE) ? len_clamped : len_reg;
    // Credit check: everything requested must fit in the FIFO when it lands.
    assign room        = (int'(fifo_count) + int'(in_flight)) < DEPTH;
    assign issue       = !rst && room &&
                         ((accept && (len_clamped != '0)) || (state == ST_ISSUE));
    assign row_end     = (row_cnt == cur_len - 1'b1);
    assign issue_last  = issue && row_end && (poly_cnt == PIDX_W'(NUM_POLY - 1));

    assign ret_poly    = dl_poly[D-1];
    assign ret_data    = doutb[int'(ret_poly)*BEAT_W +: BEAT_W];

    assign m_valid     = !fifo_empty;
    assign {head_last, m_poly, m_data} = head;
    assign m_last      = m_valid && head_last;
    assign xfer        = m_valid && m_ready;
    assign busy        = (state != ST_IDLE);

    // Row address for the selected polynomial on all its banks; others stay 0.
    always_comb begin
        addrb = '0;
        if (issue) begin
            for (int b = 0; b < NUM_BASE_BANK; b++) begin
                addrb[(int'(poly_cnt)*NUM_BASE_BANK + b)*ADDR_WIDTH +: ADDR_WIDTH] =
                    row_cnt[ADDR_WIDTH-1:0];
            end
        end
    end

    // Next-state logic: ISSUE until the final read leaves, DRAIN until its beat is taken.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && (len_clamped != '0)) begin
                    state_next = issue_last ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && m_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, sampled length, row/poly walk counters and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_reg  <= '0;
            row_cnt  <= '0;
            poly_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (accept && (len_clamped == '0)) || (xfer && m_last);
            if (accept) begin
                len_reg <= len_clamped;
            end
            if (issue) begin
                if (row_end) begin
                    row_cnt  <= '0;
                    poly_cnt <= (poly_cnt == PIDX_W'(NUM_POLY - 1)) ? '0 : poly_cnt + 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

    // Valid/last tags ride alongside each read for the BRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_vld    <= '0;
            dl_last   <= '0;
            in_flight <= '0;
        end else begin
            dl_vld[0]  <= issue;
            dl_last[0] <= issue_last;
            for (int i = 1; i < D; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_last[i] <= dl_last[i-1];
            end
            in_flight <= in_flight + CNT_W'(issue) - CNT_W'(dl_vld[D-1]);
        end
    end

    // Polynomial index tag follows the same latency; qualified by dl_vld.
    always_ff @(posedge clk) begin
        dl_poly[0] <= poly_cnt;
        for (int i = 1; i < D; i++) begin
            dl_poly[i] <= dl_poly[i-1];
        end
    end

    rd_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dl_vld[D-1]),
        .wr_data ({dl_last[D-1], ret_poly, ret_data}),
        .rd_en   (m_ready),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_polyvec_reader.sv
// Directed bench for polyvec_reader with a behavioural banked-BRAM model.
module tb_polyvec_reader;

    localparam int COE = 39;
    localparam int A   = 9;
    localparam int NP  = 8;
    localparam int NB  = 8;
    localparam int D   = polyvec_reader_pkg::BRAM_DELAY;
    localparam int AT  = A * NB * NP;
    localparam int DT  = COE * NB * NP;
    localparam int BW  = COE * NB;

    logic          clk;
    logic          rst;
    logic          start;
    logic [A:0]    len;
    logic [AT-1:0] addrb;
    logic [DT-1:0] doutb;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] m_data;
    logic [2:0]    m_poly;
    logic          m_last;
    logic          busy;
    logic          done;

    polyvec_reader #(
        .COE_WIDTH         (COE),
        .ADDR_WIDTH        (A),
        .NUM_POLY          (NP),
        .NUM_BASE_BANK     (NB),
        .COMMON_BRAM_DELAY (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .addrb   (addrb),
        .doutb   (doutb),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_poly  (m_poly),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [COE-1:0] coef(input int p, input int b, input int r);
        logic [31:0] pv, bv, rv;
        pv = p;
        bv = b;
        rv = r;
        return {pv[7:0], bv[7:0], rv[15:0], 7'h5A};
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int p, input int r);
        logic [BW-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++) v[b*COE +: COE] = coef(p, b, r);
        return v;
    endfunction

    // BRAM model: data appears D cycles after the address is presented.
    logic [AT-1:0] hist [D];
    always_ff @(posedge clk) begin
        hist[0] <= addrb;
        for (int i = 1; i < D; i++) hist[i] <= hist[i-1];
    end
    always_comb begin
        doutb = '0;
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < NB; b++)
                doutb[(p*NB+b)*COE +: COE] = coef(p, b, int'(hist[D-1][(p*NB+b)*A +: A]));
    end

    function automatic bit addr_ok(input logic [AT-1:0] a);
        int hits;
        bit nz, same;
        logic [A-1:0] r0, f;
        hits = 0;
        for (int p = 0; p < NP; p++) begin
            nz = 0;
            same = 1;
            r0 = a[(p*NB)*A +: A];
            for (int b = 0; b < NB; b++) begin
                f = a[(p*NB+b)*A +: A];
                if (f != '0) nz = 1;
                if (f != r0) same = 0;
            end
            if (nz) begin
                hits++;
                if (!same) return 0;
            end
        end
        return hits <= 1;
    endfunction

    int total, bad, cyc_no;
    int beat_idx, len_eff, model_beats, first_vld_cyc, last_beat_cyc;
    int done_cnt, done_cyc, last_cnt, start_cyc, vld_seen;
    bit prev_stall, final_xfer, no_issue_chk, busy_at1;
    logic [BW-1:0] hold_data;
    logic [2:0]    hold_poly;
    logic          hold_last;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic sb_reset(input int l);
        len_eff       = (l > (1 << A)) ? (1 << A) : l;
        model_beats   = NP * len_eff;
        beat_idx      = 0;
        first_vld_cyc = -1;
        last_beat_cyc = -1;
        done_cnt      = 0;
        done_cyc      = -1;
        last_cnt      = 0;
        vld_seen      = 0;
        prev_stall    = 0;
        final_xfer    = 0;
        no_issue_chk  = 0;
        busy_at1      = 0;
        start_cyc     = cyc_no;
    endtask

    task automatic check_cycle();
        int ep, er;
        if (addrb != '0) begin
            total++;
            if (!addr_ok(addrb)) begin
                bad++;
                $display("FAIL addrb_fields: got %0h", addrb);
            end
        end
        if (no_issue_chk) cmp("stall_no_issue", 64'(addrb != '0), 64'd0);
        if (prev_stall) begin
            total++;
            if (!(m_valid && m_data == hold_data && m_poly == hold_poly && m_last == hold_last)) begin
                bad++;
                $display("FAIL hold_stable: got v=%0d p=%0d l=%0d want p=%0d l=%0d",
                         m_valid, m_poly, m_last, hold_poly, hold_last);
            end
        end
        if (cyc_no == start_cyc + 1) busy_at1 = busy;
        if (m_valid) begin
            vld_seen++;
            if (first_vld_cyc < 0) first_vld_cyc = cyc_no;
        end
        if (m_valid && m_ready) begin
            total++;
            if (beat_idx >= model_beats) begin
                bad++;
                $display("FAIL extra_beat: got beat %0d want at most %0d", beat_idx + 1, model_beats);
            end else begin
                ep = beat_idx / len_eff;
                er = beat_idx % len_eff;
                if (int'(m_poly) != ep || m_data != exp_beat(ep, er) ||
                    m_last != (ep == NP - 1 && er == len_eff - 1)) begin
                    bad++;
                    $display("FAIL beat%0d: got p=%0d l=%0d d=%0h want p=%0d r=%0d d=%0h",
                             beat_idx, m_poly, m_last, m_data, ep, er, exp_beat(ep, er));
                end
            end
            if (m_last) begin
                last_cnt++;
                final_xfer = 1;
            end
            last_beat_cyc = cyc_no;
            beat_idx++;
        end
        prev_stall = m_valid && !m_ready;
        hold_data  = m_data;
        hold_poly  = m_poly;
        hold_last  = m_last;
        if (done) begin
            done_cnt++;
            done_cyc = cyc_no;
        end
    endtask

    task automatic cycle(input logic rdy, input logic st);
        m_ready = rdy;
        start   = st;
        #1;
        check_cycle();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic run_stream(input int l, input logic [3:0] pat, input bit hold,
                              input int max_beats, input int stall_at, input int beats);
        int k, stall_cnt;
        bit stalled;
        logic rdy;
        len = (A+1)'(l);
        sb_reset(l);
        k = 0;
        stall_cnt = 0;
        stalled = 0;
        while (done_cnt == 0 && k < 20000 && !(max_beats > 0 && beat_idx >= max_beats)) begin
            if (stall_at >= 0 && !stalled && beat_idx == stall_at) stalled = 1;
            if (stalled && stall_cnt < 20) begin
                stall_cnt++;
                rdy = 1'b0;
                no_issue_chk = (stall_cnt >= 5);
            end else begin
                rdy = pat[k % 4];
                no_issue_chk = 0;
            end
            cycle(rdy, (k == 0) ? 1'b1 : (hold && !final_xfer));
            if (k == 0 && hold) len = (A+1)'(7);
            k++;
        end
        no_issue_chk = 0;
        if (max_beats > 0) return;
        if (done_cnt == 0) begin
            total++;
            bad++;
            $display("FAIL timeout len=%0d: got no done want done", l);
        end
        repeat (6) cycle(1'b1, 1'b0);
        cmp("beat_count", 64'(beat_idx), 64'(beats));
        cmp("done_count", 64'(done_cnt), 64'd1);
        cmp("last_count", 64'(last_cnt), 64'(beats > 0));
        cmp("busy_after_start", 64'(busy_at1), 64'(beats > 0));
        if (beats > 0) begin
            cmp("done_timing", 64'(done_cyc), 64'(last_beat_cyc + 1));
            cmp("first_latency", 64'(first_vld_cyc - start_cyc), 64'(D + 1));
            if (pat == 4'hF && stall_at < 0)
                cmp("gapless", 64'(last_beat_cyc - first_vld_cyc), 64'(beats - 1));
        end else begin
            cmp("empty_done_timing", 64'(done_cyc), 64'(start_cyc + 1));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        cmp({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        cmp({tag, "_m_last"},  64'(m_last),  64'd0);
        cmp({tag, "_busy"},    64'(busy),    64'd0);
        cmp({tag, "_done"},    64'(done),    64'd0);
        cmp({tag, "_addrb"},   64'(addrb != '0), 64'd0);
    endtask

    typedef struct {
        int         len;
        logic [3:0] pat;
        bit         hold;
        int         beats;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{len: 512,  pat: 4'hF, hold: 0, beats: 4096};
        vecs[1] = '{len: 3,    pat: 4'h9, hold: 0, beats: 24};
        vecs[2] = '{len: 1,    pat: 4'hF, hold: 0, beats: 8};
        vecs[3] = '{len: 1023, pat: 4'hA, hold: 0, beats: 4096};
        vecs[4] = '{len: 0,    pat: 4'hF, hold: 0, beats: 0};
        vecs[5] = '{len: 5,    pat: 4'hF, hold: 1, beats: 40};

        total   = 0;
        bad     = 0;
        cyc_no  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        len     = '0;
        sb_reset(0);
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            run_stream(vecs[i].len, vecs[i].pat, vecs[i].hold, 0, -1, vecs[i].beats);

        // Twenty-cycle back-pressure in the middle of a stream.
        run_stream(20, 4'hF, 0, 0, 30, 160);

        // Reset after 100 beats, then a fresh stream from poly 0, row 0.
        run_stream(512, 4'hF, 0, 100, -1, 4096);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_reset(0);
        repeat (12) cycle(1'b1, 1'b0);
        cmp("post_reset_valid", 64'(vld_seen), 64'd0);
        run_stream(4, 4'hF, 0, 0, -1, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
